// File: rtl/mm2s_stream_checker.sv
// AXI4-Stream sink for the DMA MM2S channel: checks an incrementing-count pattern and packet
// framing, counts errors per category. Optional macro MM2S_CHK_BACKPRESSURE_EN adds LFSR tready.
module mm2s_stream_checker #(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          PKT_BEATS = 128,
  parameter int unsigned          NUM_PKTS  = 2,
  parameter logic [DATA_W-1:0]    START_VAL = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic                  FCLK_CLK0,
  input  logic                  FCLK_RESET0_N,
  input  logic                  enable,
  input  logic [DATA_W-1:0]     M_AXIS_MM2S_tdata,
  input  logic [DATA_W/8-1:0]   M_AXIS_MM2S_tkeep,
  input  logic                  M_AXIS_MM2S_tlast,
  input  logic                  M_AXIS_MM2S_tvalid,
  output logic                  M_AXIS_MM2S_tready,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic [CNT_W-1:0]      data_err_cnt,
  output logic [CNT_W-1:0]      last_err_cnt,
  output logic [CNT_W-1:0]      keep_err_cnt,
  output logic                  err,
  output logic                  done
);

  localparam int unsigned      IDX_W      = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PKT_BEATS - 1);
  localparam logic [CNT_W-1:0] PKT_TARGET = CNT_W'(NUM_PKTS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  state_e            r_state;
  logic              r_tready;
  logic [DATA_W-1:0] r_expected;
  logic [IDX_W-1:0]  r_beat_idx;
  logic              r_miss_seen;
  logic [CNT_W-1:0]  r_pkt_cnt, r_data_err, r_last_err, r_keep_err;
  logic              r_err, r_done;

  // Reset asserts asynchronously but is released two edges later.
  always_ff @(posedge FCLK_CLK0 or negedge FCLK_RESET0_N) begin
    if (!FCLK_RESET0_N) r_rst_sync <= 2'b00;
    else                r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic             w_accept, w_data_bad, w_keep_bad, w_at_last, w_last_bad;
  logic [CNT_W-1:0] w_pkt_inc;
  logic             w_run_ready, w_arm_ready;

  assign w_accept   = M_AXIS_MM2S_tvalid && r_tready;
  assign w_data_bad = M_AXIS_MM2S_tdata != r_expected;
  assign w_keep_bad = M_AXIS_MM2S_tkeep != '1;
  assign w_at_last  = r_beat_idx == LAST_IDX;
  // Missing tlast is flagged once; the late tlast then closes the packet cleanly.
  assign w_last_bad = (M_AXIS_MM2S_tlast && !w_at_last) ||
                      (w_at_last && !M_AXIS_MM2S_tlast && !r_miss_seen);
  assign w_pkt_inc  = sat_inc(r_pkt_cnt);

`ifdef MM2S_CHK_BACKPRESSURE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;
  assign w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_run_ready = w_lfsr_nxt[0] | w_lfsr_nxt[1];
  assign w_arm_ready = LFSR_SEED[0] | LFSR_SEED[1];

  always_ff @(posedge FCLK_CLK0 or negedge w_rst_n) begin
    if (!w_rst_n)                      r_lfsr <= LFSR_SEED;
    else if (r_state == StIdle)        r_lfsr <= LFSR_SEED;
    else if (r_state == StRun)         r_lfsr <= w_lfsr_nxt;
  end
`else
  assign w_run_ready = 1'b1;
  assign w_arm_ready = 1'b1;
`endif

  always_ff @(posedge FCLK_CLK0 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= StIdle;
      r_tready    <= 1'b0;
      r_expected  <= START_VAL;
      r_beat_idx  <= '0;
      r_miss_seen <= 1'b0;
      r_pkt_cnt   <= '0;
      r_data_err  <= '0;
      r_last_err  <= '0;
      r_keep_err  <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (enable) begin
            r_state     <= StRun;
            r_tready    <= w_arm_ready;
            r_expected  <= START_VAL;
            r_beat_idx  <= '0;
            r_miss_seen <= 1'b0;
            r_pkt_cnt   <= '0;
            r_data_err  <= '0;
            r_last_err  <= '0;
            r_keep_err  <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
          end
        end
        StRun: begin
          if (w_accept) begin
            // Matching or not, the next expected value follows the received one.
            r_expected <= M_AXIS_MM2S_tdata + DATA_W'(1);
            if (w_data_bad) r_data_err <= sat_inc(r_data_err);
            if (w_keep_bad) r_keep_err <= sat_inc(r_keep_err);
            if (w_last_bad) r_last_err <= sat_inc(r_last_err);
            if (w_data_bad || w_keep_bad || w_last_bad) r_err <= 1'b1;
            if (M_AXIS_MM2S_tlast) begin
              r_pkt_cnt   <= w_pkt_inc;
              r_beat_idx  <= '0;
              r_miss_seen <= 1'b0;
            end else if (w_at_last) begin
              r_miss_seen <= 1'b1;
            end else begin
              r_beat_idx  <= r_beat_idx + IDX_W'(1);
            end
          end
          if (!enable) begin
            r_state  <= StIdle;
            r_tready <= 1'b0;
          end else if (w_accept && M_AXIS_MM2S_tlast && (w_pkt_inc == PKT_TARGET)) begin
            r_state  <= StDone;
            r_tready <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_tready <= w_run_ready;
          end
        end
        StDone: begin
          if (!enable) r_state <= StIdle;
        end
        default: begin
          r_state  <= StIdle;
          r_tready <= 1'b0;
        end
      endcase
    end
  end

  assign M_AXIS_MM2S_tready = r_tready;
  assign pkt_cnt            = r_pkt_cnt;
  assign data_err_cnt       = r_data_err;
  assign last_err_cnt       = r_last_err;
  assign keep_err_cnt       = r_keep_err;
  assign err                = r_err;
  assign done               = r_done;

endmodule

// File: tb/tb_mm2s_stream_checker.sv
// Randomized bench for mm2s_stream_checker, checked against a transaction-level model that
// tracks unbounded beat counts per packet and applies the checking rules beat by beat.
module tb_mm2s_stream_checker;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PKT_BEATS = 128;
  localparam int unsigned NUM_PKTS  = 2;
  localparam int unsigned CNT_W     = 16;
  localparam logic [31:0] START_VAL = 32'hFFFF_FFFE;
  localparam int          CNT_MAX   = 65535;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [DATA_W-1:0] tdata;
  logic [3:0]        tkeep;
  logic              tlast, tvalid, tready;
  logic [CNT_W-1:0]  pkt_cnt, data_err_cnt, last_err_cnt, keep_err_cnt;
  logic              err, done;

  always #5 clk = ~clk;

  mm2s_stream_checker #(
    .DATA_W   (DATA_W),
    .PKT_BEATS(PKT_BEATS),
    .NUM_PKTS (NUM_PKTS),
    .START_VAL(START_VAL),
    .CNT_W    (CNT_W)
  ) u_dut (
    .FCLK_CLK0         (clk),
    .FCLK_RESET0_N     (rst_n),
    .enable            (enable),
    .M_AXIS_MM2S_tdata (tdata),
    .M_AXIS_MM2S_tkeep (tkeep),
    .M_AXIS_MM2S_tlast (tlast),
    .M_AXIS_MM2S_tvalid(tvalid),
    .M_AXIS_MM2S_tready(tready),
    .pkt_cnt           (pkt_cnt),
    .data_err_cnt      (data_err_cnt),
    .last_err_cnt      (last_err_cnt),
    .keep_err_cnt      (keep_err_cnt),
    .err               (err),
    .done              (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;

  // Reference model state
  logic [31:0] m_exp;
  int          m_beats, m_pkt, m_derr, m_lerr, m_kerr;
  bit          m_err, m_done, m_run;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic model_reset();
    m_exp = START_VAL; m_beats = 0; m_pkt = 0; m_derr = 0; m_lerr = 0; m_kerr = 0;
    m_err = 0; m_done = 0; m_run = 0;
  endtask

  task automatic model_beat(input logic [31:0] d, input logic [3:0] k, input bit l);
    if (!m_run) check_eq("accept_while_stopped", 1, 0);
    if (d != m_exp) begin m_derr = sat(m_derr); m_err = 1; end
    m_exp = d + 32'd1;
    if (k != 4'hF) begin m_kerr = sat(m_kerr); m_err = 1; end
    if (l) begin
      if (m_beats < PKT_BEATS - 1) begin m_lerr = sat(m_lerr); m_err = 1; end
      m_pkt   = sat(m_pkt);
      m_beats = 0;
      if (m_pkt == NUM_PKTS) begin m_done = 1; m_run = 0; end
    end else begin
      if (m_beats == PKT_BEATS - 1) begin m_lerr = sat(m_lerr); m_err = 1; end
      m_beats++;
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq($sformatf("%s.pkt_cnt", tag),      pkt_cnt,      m_pkt);
    check_eq($sformatf("%s.data_err_cnt", tag), data_err_cnt, m_derr);
    check_eq($sformatf("%s.last_err_cnt", tag), last_err_cnt, m_lerr);
    check_eq($sformatf("%s.keep_err_cnt", tag), keep_err_cnt, m_kerr);
    check_eq($sformatf("%s.err", tag),          err,          m_err);
    check_eq($sformatf("%s.done", tag),         done,         m_done);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    tvalid = 1'b0;
    enable = 1'b1;
    cycle();
    model_reset();
    m_run = 1;
`ifndef MM2S_CHK_BACKPRESSURE_EN
    check_eq("arm_tready", tready, 1);
`endif
  endtask

  task automatic disarm();
    tvalid = 1'b0;
    enable = 1'b0;
    cycle();
    m_run = 0;
    cycle();
  endtask

  // Present one beat until accepted (bounded), optionally after idle cycles.
  task automatic beat(input logic [31:0] d, input logic [3:0] k, input bit l, input int gap);
    bit acc;
    for (int g = 0; g < gap; g++) begin tvalid = 1'b0; cycle(); end
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
    acc = 0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = tready;
      if (!acc) stalls++;
      cycle();
    end
    if (!acc) check_eq("beat_accept", acc, 1);
    else      model_beat(d, k, l);
  endtask

  task automatic run_seq(input int n, input int la, input int lb, input int bad_at,
                         input int chk_at, input bit gaps);
    logic [31:0] nxt, d, x;
    nxt = START_VAL;
    for (int i = 0; i < n; i++) begin
      d = nxt;
      if (i == bad_at) begin
        x = $urandom;
        if (x == 0) x = 32'h1;
        d = nxt ^ x;
      end
      nxt = d + 32'd1;
      beat(d, 4'hF, (i == la) || (i == lb), gaps ? int'($urandom_range(0, 2)) : 0);
      if (i == chk_at) compare_all($sformatf("seq_mid%0d", i));
    end
  endtask

  initial begin
    logic [31:0] nxt, d;
    logic [3:0]  k;
    bit          l;
    int          li, nb;

    rst_n = 1'b0; enable = 1'b0; tvalid = 1'b0; tdata = '0; tkeep = 4'hF; tlast = 1'b0;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
    check_eq("reset.tready", tready, 0);
    compare_all("reset");

    // Clean stream with tvalid held high, including the wrap through zero
    arm();
    run_seq(256, 127, 255, -1, -1, 0);
    compare_all("clean");
    check_eq("clean.done_const", done, 1);
    check_eq("clean.pkt_const", pkt_cnt, 2);
    check_eq("clean.tready_after", tready, 0);
    for (int i = 0; i < 5; i++) begin
      tdata = $urandom; tkeep = 4'h3; tlast = 1'b1;
      cycle();
    end
    compare_all("done_ignore");
    check_eq("done_ignore.tready", tready, 0);
    disarm();
    compare_all("done_hold");

    // Corrupted beat 10, stream resyncs to it
    arm();
    run_seq(256, 127, 255, 10, -1, 1);
    compare_all("corrupt");
    check_eq("corrupt.derr_const", data_err_cnt, 1);
    disarm();

    // Early tlast on beat 63
    arm();
    run_seq(192, 63, 191, -1, 63, 0);
    compare_all("early");
    check_eq("early.lerr_const", last_err_cnt, 1);
    disarm();

    // Missing tlast: late tlast on beat 130
    arm();
    run_seq(259, 130, 258, -1, 129, 1);
    compare_all("missing");
    check_eq("missing.lerr_const", last_err_cnt, 1);
    disarm();

    // Disarm mid-packet with a beat on the same edge, then re-arm
    arm();
    run_seq(40, -1, -1, -1, -1, 0);
    tdata = START_VAL + 32'd40; tkeep = 4'hF; tlast = 1'b0; tvalid = 1'b1; enable = 1'b0;
    @(negedge clk);
    l = tready;
    cycle();
    if (l) model_beat(tdata, 4'hF, 1'b0);
    m_run = 0;
    tvalid = 1'b0;
    check_eq("disarm.tready", tready, 0);
    compare_all("disarm");
    repeat (3) cycle();
    compare_all("disarm_hold");
    arm();
    compare_all("rearm");
    run_seq(256, 127, 255, -1, -1, 0);
    compare_all("rearm_stream");
    disarm();

    // Random mixed errors and framing
    for (int r = 0; r < 6; r++) begin
      arm();
      nxt = START_VAL; li = 0; nb = 0;
      while (m_run && nb < 400) begin
        d = nxt;
        if ($urandom_range(0, 31) == 0) d = $urandom;
        nxt = d + 32'd1;
        k = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
        l = (li >= PKT_BEATS - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 63) == 0);
        li = l ? 0 : li + 1;
        beat(d, k, l, int'($urandom_range(0, 1)));
        nb++;
      end
      tvalid = 1'b0;
      compare_all($sformatf("rand%0d", r));
      disarm();
      compare_all($sformatf("rand%0d_idle", r));
    end

    // Keep-error saturation without tlast; beat index saturates at the last slot
    arm();
    nxt = START_VAL;
    for (int i = 0; i < 65540; i++) begin
      beat(nxt, 4'h7, 1'b0, 0);
      nxt = nxt + 32'd1;
    end
    tvalid = 1'b0;
    compare_all("sat");
    check_eq("sat.kerr_const", keep_err_cnt, 16'hFFFF);
    check_eq("sat.lerr_const", last_err_cnt, 1);
    check_eq("sat.derr_const", data_err_cnt, 0);
    disarm();

`ifdef MM2S_CHK_BACKPRESSURE_EN
    check_eq("bp_stall_seen", (stalls > 0), 1);
`else
    check_eq("no_stall", stalls, 0);
`endif

    // Async reset mid-packet
    arm();
    run_seq(20, -1, -1, -1, -1, 0);
    rst_n = 1'b0;
    #1;
    check_eq("rst.tready", tready, 0);
    model_reset();
    compare_all("rst");
    tvalid = 1'b0; enable = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
    compare_all("post_rst");
    check_eq("post_rst.tready", tready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
